apb_fsm_controller: RTL and testbench

Sequencing controller of the AHB-to-APB bridge. Accepts pipelined AHB transfers from the AHB slave side, decodes the address to one of three APB peripherals, and drives the registered APB setup/access sequence into `apb_interface`. It stalls the AHB side with `Hreadyout` until each APB transfer completes. Back-to-back transfers are pipelined: a new request is accepted in the access cycle of the current one.

---
 rtl/apb_fsm_controller.sv | 163 ++++++++++++++++
 tb/tb_apb_fsm_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_fsm_controller.sv
// Sequencing controller of the AHB-to-APB bridge: decodes AHB transfers to one of
// three APB slaves and drives the registered APB setup/access sequence.
module apb_fsm_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic              Hwrite,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Prdata,
  output logic              Hreadyout,
  output logic [DATA_W-1:0] Hrdata,
  output logic              Pwrite,
  output logic              Penable,
  output logic [2:0]        Pselx,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata
);

  localparam int unsigned SEL_W    = 3;
  localparam int unsigned REGION_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WWAIT   = 3'd1,
    ST_RSETUP  = 3'd2,
    ST_RENABLE = 3'd3,
    ST_WSETUP  = 3'd4,
    ST_WENABLE = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SEL_W-1:0]    pselx_q, pselx_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                hreadyout_q, hreadyout_d;

  logic [SEL_W-1:0]    dec_sel;
  logic                in_range;
  logic                can_accept;
  logic                accept;

  // 64 MB windows selected by the top six address bits
  always_comb begin
    dec_sel = '0;
    case (Haddr[ADDR_W-1 -: REGION_W])
      6'b100000: dec_sel = 3'b001;
      6'b100001: dec_sel = 3'b010;
      6'b100010: dec_sel = 3'b100;
      default:   dec_sel = '0;
    endcase
  end

  assign in_range   = |dec_sel;
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_RENABLE) ||
                      (state_q == ST_WENABLE);
  assign accept     = valid && in_range && can_accept;

  // Next-state and next-output decode; APB outputs follow state_d so they
  // change exactly on state entry.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    pselx_d     = '0;
    penable_d   = 1'b0;
    pwrite_d    = 1'b0;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    hreadyout_d = 1'b1;

    case (state_q)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (accept) begin
          sel_d   = dec_sel;
          addr_d  = Haddr;
          state_d = Hwrite ? ST_WWAIT : ST_RSETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WWAIT: begin
        // Write data arrives one cycle after the address phase
        pwdata_d = Hwdata;
        state_d  = ST_WSETUP;
      end
      ST_RSETUP: state_d = ST_RENABLE;
      ST_WSETUP: state_d = ST_WENABLE;
      default:   state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_WWAIT: begin
        hreadyout_d = 1'b0;
      end
      ST_RSETUP: begin
        pselx_d     = sel_d;
        paddr_d     = addr_d;
        hreadyout_d = 1'b0;
      end
      ST_RENABLE: begin
        pselx_d     = sel_d;
        paddr_d     = addr_d;
        penable_d   = 1'b1;
      end
      ST_WSETUP: begin
        pselx_d     = sel_d;
        paddr_d     = addr_d;
        pwrite_d    = 1'b1;
        hreadyout_d = 1'b0;
      end
      ST_WENABLE: begin
        pselx_d     = sel_d;
        paddr_d     = addr_d;
        pwrite_d    = 1'b1;
        penable_d   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      addr_q      <= '0;
      pselx_q     <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      hreadyout_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      hreadyout_q <= hreadyout_d;
    end
  end

  // Read data is a straight pass-through during the access phase only
  assign Hrdata    = (state_q == ST_RENABLE) ? Prdata : '0;
  assign Hreadyout = hreadyout_q;
  assign Pwrite    = pwrite_q;
  assign Penable   = penable_q;
  assign Pselx     = pselx_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller: inputs driven and outputs checked on the
// falling clock edge, one task per scenario.
module tb_apb_fsm_controller;

  logic        Hclk;
  logic        Hreset;
  logic        valid;
  logic [31:0] Haddr;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        Hreadyout;
  logic [31:0] Hrdata;
  logic        Pwrite;
  logic        Penable;
  logic [2:0]  Pselx;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic pen_prev = 1'b0;

  apb_fsm_controller #(.ADDR_W(32), .DATA_W(32)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Haddr(Haddr), .Hwrite(Hwrite),
    .Hwdata(Hwdata), .Prdata(Prdata), .Hreadyout(Hreadyout), .Hrdata(Hrdata),
    .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx), .Paddr(Paddr), .Pwdata(Pwdata)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  // Counts rising edges of Penable
  always @(negedge Hclk) begin
    if (Penable && !pen_prev) pulses = pulses + 1;
    pen_prev = Penable;
  end

  task automatic test_reset();
    Hreset = 1'b1;
    repeat (2) @(negedge Hclk);
    Hreset = 1'b0;
    total++; if (Pselx !== 3'b000) begin bad++; $display("FAIL reset_pselx got=%b exp=000", Pselx); end
    total++; if (Penable !== 1'b0) begin bad++; $display("FAIL reset_penable got=%b exp=0", Penable); end
    total++; if (Pwrite !== 1'b0) begin bad++; $display("FAIL reset_pwrite got=%b exp=0", Pwrite); end
    total++; if (Paddr !== 32'h0) begin bad++; $display("FAIL reset_paddr got=%h exp=0", Paddr); end
    total++; if (Pwdata !== 32'h0) begin bad++; $display("FAIL reset_pwdata got=%h exp=0", Pwdata); end
    total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL reset_hready got=%b exp=1", Hreadyout); end
    total++; if (Hrdata !== 32'h0) begin bad++; $display("FAIL reset_hrdata got=%h exp=0", Hrdata); end
  endtask

  task automatic test_single_read();
    Prdata = 32'h5A; valid = 1'b1; Haddr = 32'h8000_0010; Hwrite = 1'b0;
    @(negedge Hclk); valid = 1'b0;
    total++; if (Pselx !== 3'b001) begin bad++; $display("FAIL rd_setup_pselx got=%b exp=001", Pselx); end
    total++; if (Penable !== 1'b0) begin bad++; $display("FAIL rd_setup_penable got=%b exp=0", Penable); end
    total++; if (Paddr !== 32'h8000_0010) begin bad++; $display("FAIL rd_setup_paddr got=%h exp=80000010", Paddr); end
    total++; if (Hreadyout !== 1'b0) begin bad++; $display("FAIL rd_setup_hready got=%b exp=0", Hreadyout); end
    total++; if (Hrdata !== 32'h0) begin bad++; $display("FAIL rd_setup_hrdata got=%h exp=0", Hrdata); end
    @(negedge Hclk);
    total++; if (Penable !== 1'b1) begin bad++; $display("FAIL rd_enable_penable got=%b exp=1", Penable); end
    total++; if (Pselx !== 3'b001) begin bad++; $display("FAIL rd_enable_pselx got=%b exp=001", Pselx); end
    total++; if (Pwrite !== 1'b0) begin bad++; $display("FAIL rd_enable_pwrite got=%b exp=0", Pwrite); end
    total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL rd_enable_hready got=%b exp=1", Hreadyout); end
    total++; if (Hrdata !== 32'h5A) begin bad++; $display("FAIL rd_enable_hrdata got=%h exp=5a", Hrdata); end
    @(negedge Hclk);
    total++; if (Pselx !== 3'b000) begin bad++; $display("FAIL rd_idle_pselx got=%b exp=000", Pselx); end
    total++; if (Penable !== 1'b0) begin bad++; $display("FAIL rd_idle_penable got=%b exp=0", Penable); end
    total++; if (Hrdata !== 32'h0) begin bad++; $display("FAIL rd_idle_hrdata got=%h exp=0", Hrdata); end
    total++; if (Paddr !== 32'h8000_0010) begin bad++; $display("FAIL rd_idle_paddr_hold got=%h exp=80000010", Paddr); end
  endtask

  task automatic test_single_write();
    valid = 1'b1; Haddr = 32'h8400_0004; Hwrite = 1'b1;
    @(negedge Hclk); valid = 1'b0; Hwdata = 32'hDEAD_BEEF;
    total++; if (Hreadyout !== 1'b0) begin bad++; $display("FAIL wr_wait_hready got=%b exp=0", Hreadyout); end
    total++; if (Pselx !== 3'b000) begin bad++; $display("FAIL wr_wait_pselx got=%b exp=000", Pselx); end
    @(negedge Hclk); Hwdata = 32'h0;
    total++; if (Pselx !== 3'b010) begin bad++; $display("FAIL wr_setup_pselx got=%b exp=010", Pselx); end
    total++; if (Pwrite !== 1'b1) begin bad++; $display("FAIL wr_setup_pwrite got=%b exp=1", Pwrite); end
    total++; if (Penable !== 1'b0) begin bad++; $display("FAIL wr_setup_penable got=%b exp=0", Penable); end
    total++; if (Pwdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_setup_pwdata got=%h exp=deadbeef", Pwdata); end
    total++; if (Paddr !== 32'h8400_0004) begin bad++; $display("FAIL wr_setup_paddr got=%h exp=84000004", Paddr); end
    total++; if (Hreadyout !== 1'b0) begin bad++; $display("FAIL wr_setup_hready got=%b exp=0", Hreadyout); end
    @(negedge Hclk);
    total++; if (Penable !== 1'b1) begin bad++; $display("FAIL wr_enable_penable got=%b exp=1", Penable); end
    total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL wr_enable_hready got=%b exp=1", Hreadyout); end
    total++; if (Pwdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_enable_pwdata got=%h exp=deadbeef", Pwdata); end
    total++; if (Hrdata !== 32'h0) begin bad++; $display("FAIL wr_enable_hrdata got=%h exp=0", Hrdata); end
    @(negedge Hclk);
    total++; if (Pselx !== 3'b000) begin bad++; $display("FAIL wr_idle_pselx got=%b exp=000", Pselx); end
    total++; if (Pwrite !== 1'b0) begin bad++; $display("FAIL wr_idle_pwrite got=%b exp=0", Pwrite); end
    total++; if (Pwdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_idle_pwdata_hold got=%h exp=deadbeef", Pwdata); end
  endtask

  task automatic test_back_to_back();
    Prdata = 32'hCAFE_0001;
    valid = 1'b1; Haddr = 32'h8800_0000; Hwrite = 1'b1;
    @(negedge Hclk); valid = 1'b0; Hwdata = 32'h1234_5678;
    @(negedge Hclk);
    total++; if (Pselx !== 3'b100) begin bad++; $display("FAIL b2b_wsetup_pselx got=%b exp=100", Pselx); end
    @(negedge Hclk);
    total++; if (Penable !== 1'b1) begin bad++; $display("FAIL b2b_wenable_penable got=%b exp=1", Penable); end
    total++; if (Pwdata !== 32'h1234_5678) begin bad++; $display("FAIL b2b_wenable_pwdata got=%h exp=12345678", Pwdata); end
    valid = 1'b1; Haddr = 32'h8000_0008; Hwrite = 1'b0;
    @(negedge Hclk); valid = 1'b0;
    total++; if (Pselx !== 3'b001) begin bad++; $display("FAIL b2b_rsetup_pselx got=%b exp=001", Pselx); end
    total++; if (Penable !== 1'b0) begin bad++; $display("FAIL b2b_rsetup_penable got=%b exp=0", Penable); end
    total++; if (Pwrite !== 1'b0) begin bad++; $display("FAIL b2b_rsetup_pwrite got=%b exp=0", Pwrite); end
    total++; if (Paddr !== 32'h8000_0008) begin bad++; $display("FAIL b2b_rsetup_paddr got=%h exp=80000008", Paddr); end
    @(negedge Hclk);
    total++; if (Penable !== 1'b1) begin bad++; $display("FAIL b2b_renable_penable got=%b exp=1", Penable); end
    total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL b2b_renable_hready got=%b exp=1", Hreadyout); end
    total++; if (Hrdata !== 32'hCAFE_0001) begin bad++; $display("FAIL b2b_renable_hrdata got=%h exp=cafe0001", Hrdata); end
    @(negedge Hclk);
    total++; if (Pselx !== 3'b000) begin bad++; $display("FAIL b2b_idle_pselx got=%b exp=000", Pselx); end
  endtask

  task automatic test_out_of_range();
    valid = 1'b1; Haddr = 32'h9000_0000; Hwrite = 1'b0;
    repeat (2) begin
      @(negedge Hclk);
      total++; if (Pselx !== 3'b000) begin bad++; $display("FAIL oor_idle_pselx got=%b exp=000", Pselx); end
      total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL oor_idle_hready got=%b exp=1", Hreadyout); end
      total++; if (Penable !== 1'b0) begin bad++; $display("FAIL oor_idle_penable got=%b exp=0", Penable); end
    end
    Haddr = 32'h8C00_0000;
    @(negedge Hclk);
    total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL oor_8c_hready got=%b exp=1", Hreadyout); end
    Haddr = 32'h7FFF_FFFC;
    @(negedge Hclk);
    total++; if (Pselx !== 3'b000) begin bad++; $display("FAIL oor_7f_pselx got=%b exp=000", Pselx); end
    // Top of the third window is still in range
    Haddr = 32'h8BFF_FFFC;
    @(negedge Hclk); valid = 1'b0;
    total++; if (Pselx !== 3'b100) begin bad++; $display("FAIL edge_8bff_pselx got=%b exp=100", Pselx); end
    total++; if (Paddr !== 32'h8BFF_FFFC) begin bad++; $display("FAIL edge_8bff_paddr got=%h exp=8bfffffc", Paddr); end
    @(negedge Hclk);
    valid = 1'b1; Haddr = 32'h9000_0000;
    @(negedge Hclk); valid = 1'b0;
    total++; if (Pselx !== 3'b000) begin bad++; $display("FAIL oor_renable_pselx got=%b exp=000", Pselx); end
    total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL oor_renable_hready got=%b exp=1", Hreadyout); end
    total++; if (Penable !== 1'b0) begin bad++; $display("FAIL oor_renable_penable got=%b exp=0", Penable); end
  endtask

  task automatic test_reset_in_wsetup();
    valid = 1'b1; Haddr = 32'h8400_0000; Hwrite = 1'b1;
    @(negedge Hclk); valid = 1'b0; Hwdata = 32'hA5A5_A5A5;
    @(negedge Hclk);
    total++; if (Pselx !== 3'b010) begin bad++; $display("FAIL rst_wsetup_pselx got=%b exp=010", Pselx); end
    Hreset = 1'b1;
    @(negedge Hclk); Hreset = 1'b0;
    total++; if (Pselx !== 3'b000) begin bad++; $display("FAIL rst_pselx got=%b exp=000", Pselx); end
    total++; if (Penable !== 1'b0) begin bad++; $display("FAIL rst_penable got=%b exp=0", Penable); end
    total++; if (Paddr !== 32'h0) begin bad++; $display("FAIL rst_paddr got=%h exp=0", Paddr); end
    total++; if (Pwdata !== 32'h0) begin bad++; $display("FAIL rst_pwdata got=%h exp=0", Pwdata); end
    total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL rst_hready got=%b exp=1", Hreadyout); end
    @(negedge Hclk);
    total++; if (Penable !== 1'b0) begin bad++; $display("FAIL rst_no_wenable got=%b exp=0", Penable); end
  endtask

  task automatic test_ten_reads();
    logic [2:0]  exp_sel;
    logic [31:0] exp_addr;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0:       begin exp_sel = 3'b001; exp_addr = 32'h8000_0000 + 32'(i * 4); end
        1:       begin exp_sel = 3'b010; exp_addr = 32'h8400_0000 + 32'(i * 4); end
        default: begin exp_sel = 3'b100; exp_addr = 32'h8800_0000 + 32'(i * 4); end
      endcase
      valid = 1'b1; Haddr = exp_addr; Hwrite = 1'b0;
      @(negedge Hclk); valid = 1'b0; Prdata = 32'h1000 + 32'(i);
      total++; if (Pselx !== exp_sel) begin bad++; $display("FAIL b10_setup_pselx i=%0d got=%b exp=%b", i, Pselx, exp_sel); end
      total++; if (Penable !== 1'b0) begin bad++; $display("FAIL b10_setup_penable i=%0d got=%b exp=0", i, Penable); end
      total++; if (Paddr !== exp_addr) begin bad++; $display("FAIL b10_setup_paddr i=%0d got=%h exp=%h", i, Paddr, exp_addr); end
      @(negedge Hclk);
      total++; if (Penable !== 1'b1) begin bad++; $display("FAIL b10_enable_penable i=%0d got=%b exp=1", i, Penable); end
      total++; if (Pselx !== exp_sel) begin bad++; $display("FAIL b10_enable_pselx i=%0d got=%b exp=%b", i, Pselx, exp_sel); end
      total++; if (Hrdata !== 32'h1000 + 32'(i)) begin bad++; $display("FAIL b10_enable_hrdata i=%0d got=%h exp=%h", i, Hrdata, 32'h1000 + 32'(i)); end
    end
    @(negedge Hclk);
    total++; if (Penable !== 1'b0) begin bad++; $display("FAIL b10_final_penable got=%b exp=0", Penable); end
    total++; if (pulses !== 10) begin bad++; $display("FAIL b10_pulse_count got=%0d exp=10", pulses); end
  endtask

  initial begin
    Hreset = 1'b1; valid = 1'b0; Haddr = '0; Hwrite = 1'b0; Hwdata = '0; Prdata = '0;
    @(negedge Hclk);
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_out_of_range();
    test_reset_in_wsetup();
    test_ten_reads();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
